// File: rtl/rx_engine.sv
// Oversampled 8N1 UART receive engine: synchronizes the line, samples each bit at
// mid-bit on the shared oversampling tick and pushes good bytes to the RX FIFO.
module rx_engine #(
    parameter int unsigned OSR       = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 osr_tick_i,
    input  logic                 rx_en_i,
    input  logic                 rx_data_i,
    input  logic                 clr_frame_err_i,
    output logic [DATA_BITS-1:0] rx_fifo_wdata_o,
    output logic                 rx_fifo_wen_o,
    output logic                 rx_busy_o,
    output logic                 frame_err_o
);

    localparam int unsigned TW = $clog2(OSR);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] wdata_n;
    logic                 wen_n;
    logic                 err_n;
    logic                 err_set;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_m            <= 1'b1;
            rx_s            <= 1'b1;
            state           <= IDLE;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            rx_fifo_wdata_o <= '0;
            rx_fifo_wen_o   <= 1'b0;
            frame_err_o     <= 1'b0;
        end else begin
            rx_m            <= rx_data_i;
            rx_s            <= rx_m;
            state           <= state_n;
            tick_cnt        <= tick_n;
            bit_cnt         <= bit_n;
            shift           <= shift_n;
            rx_fifo_wdata_o <= wdata_n;
            rx_fifo_wen_o   <= wen_n;
            frame_err_o     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift;
        wdata_n   = rx_fifo_wdata_o;
        wen_n     = 1'b0;
        err_set   = 1'b0;
        rx_busy_o = (state != IDLE);

        // Disable aborts any frame in progress regardless of tick timing.
        if (state != IDLE && !rx_en_i) begin
            state_n = IDLE;
            tick_n  = '0;
            bit_n   = '0;
        end else if (osr_tick_i) begin
            case (state)
                IDLE: begin
                    if (rx_en_i && !rx_s) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_n  = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt == FULL_LAST) begin
                        tick_n = '0;
                        bit_n  = '0;
                        if (rx_s) begin
                            wen_n   = 1'b1;
                            wdata_n = shift;
                            state_n = IDLE;
                        end else begin
                            err_set = 1'b1;
                            state_n = WAIT_IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    tick_n  = '0;
                    bit_n   = '0;
                end
            endcase
        end

        if (err_set) begin
            err_n = 1'b1;
        end else if (clr_frame_err_i) begin
            err_n = 1'b0;
        end else begin
            err_n = frame_err_o;
        end
    end

endmodule

// File: tb/tb_rx_engine.sv
// Scoreboard bench for rx_engine: a serial sender pushes expected bytes, a monitor
// pops them on every FIFO write strobe; status flags are checked against a flag model.
module tb_rx_engine;

    localparam int OSR  = 16;
    localparam int DB   = 8;
    localparam int TDIV = 4;
    localparam int BP   = OSR * TDIV;

    logic          clk       = 1'b0;
    logic          reset_i   = 1'b1;
    logic          osr_tick  = 1'b0;
    logic          rx_en     = 1'b0;
    logic          rx_data   = 1'b1;
    logic          clr       = 1'b0;
    logic [DB-1:0] wdata;
    logic          wen;
    logic          busy;
    logic          ferr;

    int            checks    = 0;
    int            errors    = 0;
    int            tick_div  = 0;
    logic [DB-1:0] exp_q[$];
    logic          exp_err   = 1'b0;

    rx_engine #(.OSR(OSR), .DATA_BITS(DB)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .osr_tick_i      (osr_tick),
        .rx_en_i         (rx_en),
        .rx_data_i       (rx_data),
        .clr_frame_err_i (clr),
        .rx_fifo_wdata_o (wdata),
        .rx_fifo_wen_o   (wen),
        .rx_busy_o       (busy),
        .frame_err_o     (ferr)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_div = (tick_div + 1) % TDIV;
            osr_tick = (tick_div == 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wen: got wen=1 data=0x%0h required no write at %0t", wdata, $time);
            end else begin
                check("rx_byte", 32'(wdata), 32'(exp_q.pop_front()));
                check("busy_at_wen", 32'(busy), 32'd0);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_frame();
        @(posedge osr_tick);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        exp_err = 1'b0;
        check("rst_wen",   32'(wen),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_ferr",  32'(ferr),  32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
    endtask

    // Frame = start(0), 8 data bits LSB first, stop; bp = sender clocks per bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bp,
                              input int abort_at, input int reset_at);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (stop && abort_at < 0 && reset_at < 0) exp_q.push_back(d);
        if (!stop && abort_at < 0 && reset_at < 0) exp_err = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx_data = bits[i];
            wait_clk(bp / 2);
            if (i == reset_at) reset_mid_frame();
            wait_clk(bp - bp / 2);
            if (i == abort_at) begin
                rx_en = 1'b0;
                wait_clk(1);
                check("abort_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        wait_clk(4);
        reset_i = 1'b0;
        wait_clk(1);
        check("reset_wen",   32'(wen),   32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_ferr",  32'(ferr),  32'd0);
        check("reset_wdata", 32'(wdata), 32'd0);
        rx_en = 1'b1;
        wait_clk(BP);

        send_frame(8'hA5, 1'b1, BP, -1, -1);
        wait_clk(2 * BP);
        check("a5_ferr", 32'(ferr), 32'd0);
        check("a5_busy", 32'(busy), 32'd0);

        rx_data = 1'b0;
        wait_clk(3 * TDIV);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        wait_clk(TDIV);
        rx_data = 1'b1;
        wait_clk(12 * TDIV);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_ferr", 32'(ferr), 32'd0);

        send_frame(8'h3C, 1'b0, BP, -1, -1);
        wait_clk(40 * TDIV);
        check("brk_ferr", 32'(ferr), 32'(exp_err));
        check("brk_busy", 32'(busy), 32'd1);
        rx_data = 1'b1;
        wait_clk(4 * TDIV);
        check("brk_release_busy", 32'(busy), 32'd0);
        send_frame(8'h11, 1'b1, BP, -1, -1);
        wait_clk(BP);
        check("sticky_ferr", 32'(ferr), 32'd1);
        clr = 1'b1;
        wait_clk(1);
        clr = 1'b0;
        exp_err = 1'b0;
        check("clr_ferr", 32'(ferr), 32'd0);

        send_frame(8'h00, 1'b1, BP, -1, -1);
        send_frame(8'hFF, 1'b1, BP, -1, -1);
        send_frame(8'h5A, 1'b1, BP, -1, -1);
        wait_clk(2 * BP);

        send_frame(8'h81, 1'b1, BP, 4, -1);
        wait_clk(BP);
        check("abort_ferr", 32'(ferr), 32'd0);
        rx_en = 1'b1;
        wait_clk(BP);
        send_frame(8'h81, 1'b1, BP, -1, -1);
        wait_clk(BP);

        send_frame(8'hE5, 1'b1, BP, -1, 6);
        wait_clk(BP);
        send_frame(8'h7E, 1'b1, BP, -1, -1);
        wait_clk(BP);

        send_frame(8'h55, 1'b1, 62, -1, -1);
        send_frame(8'hAA, 1'b1, 66, -1, -1);
        wait_clk(BP);
        send_frame(8'h55, 1'b1, 66, -1, -1);
        send_frame(8'hAA, 1'b1, 62, -1, -1);
        wait_clk(BP);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       stop;
            int         bp;
            d    = 8'($urandom);
            bp   = $urandom_range(62, 66);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, stop, bp, -1, -1);
            if (!stop) begin
                rx_data = 1'b1;
                wait_clk(bp + $urandom_range(0, bp));
            end else if ($urandom_range(0, 1) == 1) begin
                wait_clk($urandom_range(1, bp));
            end
            check("rand_ferr", 32'(ferr), 32'(exp_err));
            if (exp_err && $urandom_range(0, 1) == 1) begin
                clr = 1'b1;
                wait_clk(1);
                clr = 1'b0;
                exp_err = 1'b0;
                check("rand_clr", 32'(ferr), 32'd0);
            end
        end

        wait_clk(2 * BP);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_ferr", 32'(ferr), 32'(exp_err));
        check("final_busy", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_engine.md
Name: rx_engine

Overview:
- Oversampled UART receive engine: the receive-direction counterpart of the TX engine.
- Synchronizes the asynchronous serial input and detects the start bit.
- Samples each bit at mid-bit using the shared oversampling tick and checks the stop bit.
- Pushes each good byte into the RX FIFO with a single-cycle write strobe; flags framing errors via a sticky status bit consumed by the register block. Frame format fixed 8N1, LSB first.

Parameters:
OSR, 16, oversampling ticks per bit; even, >= 4
DATA_BITS, 8, data bits per frame

Ports:
clk_i  input  1  system clock
reset_i  input  1  synchronous, active-high reset
osr_tick_i  input  1  one-cycle pulse at OSR x baud rate
rx_en_i  input  1  receiver enable (CTRL register)
rx_data_i  input  1  asynchronous serial line, idle high
clr_frame_err_i  input  1  one-cycle pulse; clears frame_err_o
rx_fifo_wdata_o  output  DATA_BITS  received byte, valid when rx_fifo_wen_o=1
rx_fifo_wen_o  output  1  RX FIFO write strobe, one clk cycle per good byte
rx_busy_o  output  1  frame reception in progress
frame_err_o  output  1  sticky framing-error flag

Behaviour:
- Interface: one clock `clk_i`; `reset_i` is synchronous and active-high.
- Reset values:
  - all outputs 0
  - synchronizer flops 1
  - state IDLE
  - tick counter, bit counter and shift register 0
- Synchronizer:
  - 2-flop synchronizer on `rx_data_i` → `rx_s`; all decisions use `rx_s` only.
  - Input-to-`rx_s` latency is 2 clk.
- Sampling: all sampling and counting advance only on clk edges where `osr_tick_i=1`.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - On a tick with `rx_en_i=1` and `rx_s=0` → START; tick_cnt=0. This is the detection tick.
  - `rx_busy_o=0`.
- START:
  - tick_cnt increments each tick; the sample occurs on the (OSR/2)-th tick after the detection tick.
  - If `rx_s=0` at the sample → DATA, tick_cnt=0, bit_cnt=0.
  - If `rx_s=1` at the sample → IDLE (false start): no write, no error.
- DATA:
  - Sample on every OSR-th tick after the previous sample.
  - Sampled bit shifts in at the MSB, shifting right, so the byte is LSB first.
  - After DATA_BITS samples → STOP.
- STOP:
  - Sample after OSR ticks.
  - `rx_s=1` → `rx_fifo_wen_o=1` and `rx_fifo_wdata_o`=shift register on the next clk cycle (registered, exactly one cycle); → IDLE.
  - `rx_s=0` → `frame_err_o` set next cycle, byte discarded (no wen); → WAIT_IDLE.
- WAIT_IDLE: remain until a tick with `rx_s=1`, then → IDLE. This prevents a held-low line (break) from retriggering.
- rx_busy_o: 1 in START, DATA, STOP and WAIT_IDLE; 0 in IDLE.
- `rx_fifo_wdata_o` holds its last value when wen=0.
- `rx_en_i` deasserted in any non-IDLE state:
  - abort to IDLE next clk
  - no write, `frame_err_o` unchanged
  - counters cleared
- frame_err_o:
  - Sticky; cleared by `clr_frame_err_i`.
  - Simultaneous set and clear → set wins.
- Reset mid-frame: immediate return to IDLE with all reset values; no write strobe is emitted.
- FIFO overflow is the FIFO's concern: the engine never stalls and ignores FIFO level.
- Back-to-back frames:
  - A new start bit is accepted on the first tick in IDLE after a good stop.
  - Minimum gap is zero stop-bit extension beyond the single stop bit.
- Counters: tick_cnt width $clog2(OSR); bit_cnt width $clog2(DATA_BITS+1). No wrap occurs within a legal frame.

Test Plan:
- Reset, OSR=16, `rx_en_i=1`, drive 0xA5 (8N1, 16 ticks/bit, ideal timing) → exactly one `rx_fifo_wen_o` pulse with `rx_fifo_wdata_o`=0xA5, `frame_err_o`=0, `rx_busy_o` low within 2 clk after wen.
- Low glitch on `rx_data_i` lasting 4 ticks, then high → no wen, `rx_busy_o` pulses then returns 0 after the START sample, `frame_err_o`=0.
- Send 0x3C with the stop bit driven 0, line held low 40 more ticks then high → no wen, `frame_err_o`=1, state stays WAIT_IDLE until the line rises. Then send 0x11 → wen with 0x11, `frame_err_o` still 1. Pulse `clr_frame_err_i` → `frame_err_o`=0.
- Back-to-back 0x00, 0xFF, 0x5A with no idle gap → three wen pulses carrying 0x00, 0xFF, 0x5A in order.
- Start 0x81, deassert `rx_en_i` after bit 3 → no wen, `rx_busy_o`=0 next clk. Re-enable and send 0x81 → wen with 0x81.
- Assert `reset_i` during bit 5 of a frame, simultaneous with `osr_tick_i` → all outputs 0 next clk, no wen. Next full frame 0x7E is received correctly.
- Baud skew: ±3% tick-rate mismatch between sender and `osr_tick_i`, bytes 0x55/0xAA → all received correctly.
